// File: rtl/wb32_decoder_n_if.sv
// rtl/wb32_decoder_n_if.sv - master-side bus and per-slave channels of the wb32 address decoder
interface wb32_decoder_n_if #(
   parameter int NSLAVES = 8
) ();
   logic                   I_wb_cyc;
   logic                   I_wb_stb;
   logic                   I_wb_we;
   logic [29:0]            I_wb_adr;
   logic [31:0]            O_wb_dat;
   logic                   O_wb_ack;
   logic                   O_wb_err;
   logic                   O_wb_stall;
   logic [NSLAVES-1:0]     O_s_stb;
   logic [NSLAVES-1:0]     I_s_ack;
   logic [NSLAVES*32-1:0]  I_s_dat;

   // master: the side that issues cycles and models the slaves' responses
   modport master (
      output I_wb_cyc, I_wb_stb, I_wb_we, I_wb_adr, I_s_ack, I_s_dat,
      input  O_wb_dat, O_wb_ack, O_wb_err, O_wb_stall, O_s_stb
   );

   modport slave (
      input  I_wb_cyc, I_wb_stb, I_wb_we, I_wb_adr, I_s_ack, I_s_dat,
      output O_wb_dat, O_wb_ack, O_wb_err, O_wb_stall, O_s_stb
   );
endinterface

// File: rtl/wb32_decoder_n.sv
// rtl/wb32_decoder_n.sv - wishbone address decoder for N slaves with watchdog and error tracking
module wb32_decoder_n #(
   parameter int                    NSLAVES       = 8,
   parameter logic [NSLAVES*30-1:0] SLAVE_BASE    = '0,
   parameter logic [NSLAVES*30-1:0] SLAVE_MASK    = '0,
   parameter int                    DEFAULT_SLAVE = -1,
   parameter int                    TIMEOUT       = 255
) (
   input  logic              I_wb_clk,
   input  logic              I_reset_n,
   wb32_decoder_n_if.slave   bus,
   output logic [29:0]       O_err_adr,
   output logic [7:0]        O_err_count
);
   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   state_t        state;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] sel_c;
   logic          hit_c;
   logic [15:0]   wd;
   logic [29:0]   adr_q;
   logic          req;
   logic          s_ack_sel;
   logic [31:0]   s_dat_sel;
   logic          unused_we;

   assign unused_we = bus.I_wb_we;
   assign req       = bus.I_wb_cyc & bus.I_wb_stb;

   // descending scan so the lowest matching index is the one left standing
   always_comb begin
      sel_c = '0;
      hit_c = 1'b0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if (((bus.I_wb_adr ^ SLAVE_BASE[i*30 +: 30]) & SLAVE_MASK[i*30 +: 30]) == 30'd0) begin
            sel_c = SW'(i);
            hit_c = 1'b1;
         end
      end
      if (!hit_c && DEFAULT_SLAVE >= 0) begin
         sel_c = SW'(DEFAULT_SLAVE);
         hit_c = 1'b1;
      end
   end

   always_comb begin
      s_ack_sel = 1'b0;
      s_dat_sel = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (sel_q == SW'(i)) begin
            s_ack_sel = bus.I_s_ack[i];
            s_dat_sel = bus.I_s_dat[i*32 +: 32];
         end
      end
   end

   always_comb begin
      bus.O_s_stb = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (I_reset_n && state == IDLE && req && hit_c && sel_c == SW'(i)) begin
            bus.O_s_stb[i] = 1'b1;
         end
      end
   end

   // a dropped cycle masks the ack so an abandoned slave can never complete
   assign bus.O_wb_ack   = I_reset_n && state == BUSY && bus.I_wb_cyc && s_ack_sel;
   assign bus.O_wb_err   = I_reset_n && state == ERR;
   assign bus.O_wb_stall = I_reset_n && state != IDLE;
   assign bus.O_wb_dat   = (I_reset_n && state == BUSY) ? s_dat_sel : 32'd0;

   always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state       <= IDLE;
         sel_q       <= '0;
         wd          <= '0;
         adr_q       <= '0;
         O_err_adr   <= '0;
         O_err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (hit_c) begin
                     sel_q <= sel_c;
                     adr_q <= bus.I_wb_adr;
                     wd    <= '0;
                     state <= BUSY;
                  end else begin
                     O_err_adr <= bus.I_wb_adr;
                     state     <= ERR;
                     if (O_err_count != 8'hFF) O_err_count <= O_err_count + 8'd1;
                  end
               end
            end
            BUSY: begin
               if (!bus.I_wb_cyc || s_ack_sel) begin
                  state <= IDLE;
               end else if (({1'b0, wd} + 17'd1) == 17'(TIMEOUT)) begin
                  O_err_adr <= adr_q;
                  state     <= ERR;
                  if (O_err_count != 8'hFF) O_err_count <= O_err_count + 8'd1;
               end else begin
                  wd <= wd + 16'd1;
               end
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb32_decoder_n.sv
// tb/tb_wb32_decoder_n.sv - randomized and directed self-checking bench for wb32_decoder_n
module tb_wb32_decoder_n;
   localparam int N   = 3;
   localparam int TMO = 4;
   localparam logic [N*30-1:0] BASE = {30'h00010000, 30'h3FFFF000, 30'h3FFFFC00};
   localparam logic [N*30-1:0] MASK = {30'h3FFF0000, 30'h3FFFF000, 30'h3FFFFF00};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] err_adr;
   logic [7:0]  err_count;

   wb32_decoder_n_if #(.NSLAVES(N)) bus ();

   wb32_decoder_n #(
      .NSLAVES(N), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
      .DEFAULT_SLAVE(-1), .TIMEOUT(TMO)
   ) dut (
      .I_wb_clk(clk), .I_reset_n(rst_n), .bus(bus),
      .O_err_adr(err_adr), .O_err_count(err_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   logic [29:0] m_base [N] = '{30'h3FFFFC00, 30'h3FFFF000, 30'h00010000};
   logic [29:0] m_mask [N] = '{30'h3FFFFF00, 30'h3FFFF000, 30'h3FFF0000};

   function automatic int decode(logic [29:0] a);
      for (int i = 0; i < N; i++)
         if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
      return -1;
   endfunction

   // reference: one outstanding transaction, an age in unacked cycles, a one-cycle error slot
   bit          m_busy, m_err;
   int          m_sel, m_age, m_ecnt;
   logic [29:0] m_adr, m_eadr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_err <= 0; m_sel <= 0; m_age <= 0;
         m_ecnt <= 0; m_adr <= '0; m_eadr <= '0;
      end else if (m_err) begin
         m_err <= 0;
      end else if (m_busy) begin
         if (!bus.I_wb_cyc || bus.I_s_ack[m_sel]) begin
            m_busy <= 0;
         end else if (m_age + 1 == TMO) begin
            m_busy <= 0; m_err <= 1; m_eadr <= m_adr;
            m_ecnt <= (m_ecnt < 255) ? m_ecnt + 1 : 255;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (bus.I_wb_cyc && bus.I_wb_stb) begin
         if (decode(bus.I_wb_adr) >= 0) begin
            m_busy <= 1; m_sel <= decode(bus.I_wb_adr); m_adr <= bus.I_wb_adr; m_age <= 0;
         end else begin
            m_err <= 1; m_eadr <= bus.I_wb_adr;
            m_ecnt <= (m_ecnt < 255) ? m_ecnt + 1 : 255;
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] e_stb;
      logic [31:0]  e_dat;
      logic         e_ack;
      if (!rst_n) begin
         check("rst_s_stb", 32'(bus.O_s_stb), 0);
         check("rst_ack", 32'(bus.O_wb_ack), 0);
         check("rst_err", 32'(bus.O_wb_err), 0);
         check("rst_stall", 32'(bus.O_wb_stall), 0);
         check("rst_err_adr", 32'(err_adr), 0);
         check("rst_err_count", 32'(err_count), 0);
      end else begin
         e_stb = '0;
         if (!m_busy && !m_err && bus.I_wb_cyc && bus.I_wb_stb && decode(bus.I_wb_adr) >= 0)
            e_stb = N'(1) << decode(bus.I_wb_adr);
         e_ack = m_busy && bus.I_wb_cyc && bus.I_s_ack[m_sel];
         e_dat = m_busy ? bus.I_s_dat[m_sel*32 +: 32] : 32'd0;
         check("cyc_s_stb", 32'(bus.O_s_stb), 32'(e_stb));
         check("cyc_ack", 32'(bus.O_wb_ack), 32'(e_ack));
         check("cyc_err", 32'(bus.O_wb_err), 32'(m_err));
         check("cyc_stall", 32'(bus.O_wb_stall), 32'(m_busy | m_err));
         check("cyc_dat", bus.O_wb_dat, e_dat);
         check("cyc_err_adr", 32'(err_adr), 32'(m_eadr));
         check("cyc_err_count", 32'(err_count), 32'(m_ecnt));
      end
   end

   task automatic drive(logic cyc, logic stb, logic [29:0] adr, logic [N-1:0] ack,
                        logic [N*32-1:0] dat);
      @(posedge clk); #1;
      bus.I_wb_cyc = cyc; bus.I_wb_stb = stb; bus.I_wb_we = 1'b0;
      bus.I_wb_adr = adr; bus.I_s_ack = ack; bus.I_s_dat = dat;
   endtask

   function automatic logic [29:0] rand_adr();
      case ($urandom_range(0, 3))
         0:       return 30'h3FFFFC00 | 30'($urandom_range(0, 255));
         1:       return 30'h3FFFF000 | 30'($urandom_range(0, 1023));
         2:       return 30'h00010000 | 30'($urandom_range(0, 65535));
         default: return 30'($urandom);
      endcase
   endfunction

   initial begin
      int  busy_n;
      bit  seen;
      logic [N-1:0] ra;
      bus.I_wb_cyc = 0; bus.I_wb_stb = 0; bus.I_wb_we = 0;
      bus.I_wb_adr = '0; bus.I_s_ack = '0; bus.I_s_dat = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // read hitting overlap of slaves 0 and 1, acked one cycle later
      drive(1, 1, 30'h3FFFFC10, 3'b000, '0);
      @(negedge clk);
      check("s1_stb_lowest", 32'(bus.O_s_stb), 32'h1);
      check("s1_stall_idle", 32'(bus.O_wb_stall), 0);
      drive(1, 0, 30'h0, 3'b001, {64'h0, 32'hDEADBEEF});
      @(negedge clk);
      check("s1_ack", 32'(bus.O_wb_ack), 1);
      check("s1_dat", bus.O_wb_dat, 32'hDEADBEEF);
      check("s1_stall_busy", 32'(bus.O_wb_stall), 1);
      drive(0, 0, 30'h0, 3'b000, '0);
      @(negedge clk);
      check("s1_stall_done", 32'(bus.O_wb_stall), 0);
      check("s1_dat_idle", bus.O_wb_dat, 0);

      // unmapped address
      drive(1, 1, 30'h00001234, 3'b000, '0);
      @(negedge clk);
      check("s3_no_stb", 32'(bus.O_s_stb), 0);
      drive(1, 0, 30'h0, 3'b000, '0);
      @(negedge clk);
      check("s3_err", 32'(bus.O_wb_err), 1);
      check("s3_err_adr", 32'(err_adr), 32'h00001234);
      check("s3_err_count", 32'(err_count), 1);
      drive(0, 0, 30'h0, 3'b000, '0);
      @(negedge clk);
      check("s3_err_one_cycle", 32'(bus.O_wb_err), 0);

      // watchdog: slave 2 never answers
      drive(1, 1, 30'h00010020, 3'b000, '0);
      @(negedge clk);
      check("s4_stb", 32'(bus.O_s_stb), 32'h4);
      drive(1, 0, 30'h0, 3'b000, '0);
      busy_n = 0; seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (bus.O_wb_err) seen = 1;
         else if (bus.O_wb_stall) busy_n++;
      end
      check("s4_err_seen", 32'(seen), 1);
      check("s4_busy_cycles", 32'(busy_n), 4);
      check("s4_err_adr", 32'(err_adr), 32'h00010020);
      @(negedge clk);
      check("s4_back_idle", 32'(bus.O_wb_stall), 0);

      // abandon, stray ack, then a clean transaction to another slave
      drive(1, 1, 30'h3FFFFC10, 3'b000, '0);
      drive(0, 0, 30'h0, 3'b000, '0);
      @(negedge clk);
      check("s5_drop_no_ack", 32'(bus.O_wb_ack), 0);
      drive(0, 0, 30'h0, 3'b001, {64'h0, 32'h0BADBAD0});
      @(negedge clk);
      check("s5_stray_ack", 32'(bus.O_wb_ack), 0);
      check("s5_stray_err", 32'(bus.O_wb_err), 0);
      drive(1, 1, 30'h00010004, 3'b000, '0);
      @(negedge clk);
      check("s5_stb2", 32'(bus.O_s_stb), 32'h4);
      drive(1, 0, 30'h0, 3'b101, {32'h12345678, 32'h0, 32'hCAFEF00D});
      @(negedge clk);
      check("s5_ack2", 32'(bus.O_wb_ack), 1);
      check("s5_dat2", bus.O_wb_dat, 32'h12345678);

      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < N; b++) ra[b] = ($urandom_range(0, 9) < 3);
         drive(($urandom_range(0, 9) != 0), 1'($urandom), rand_adr(), ra,
               {$urandom, $urandom, $urandom});
      end
      drive(0, 0, 30'h0, 3'b000, '0);
      repeat (8) @(posedge clk);

      // saturation, then reset in the middle of a transaction
      drive(1, 1, 30'h00001234, 3'b000, '0);
      repeat (600) @(posedge clk);
      drive(0, 0, 30'h0, 3'b000, '0);
      repeat (2) @(negedge clk);
      check("s6_saturate", 32'(err_count), 255);
      drive(1, 1, 30'h3FFFFC10, 3'b000, '0);
      drive(1, 1, 30'h3FFFFC10, 3'b000, '0);
      @(negedge clk);
      check("s6_busy", 32'(bus.O_wb_stall), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("s6_rst_stb", 32'(bus.O_s_stb), 0);
      check("s6_rst_stall", 32'(bus.O_wb_stall), 0);
      check("s6_rst_count", 32'(err_count), 0);
      check("s6_rst_dat", bus.O_wb_dat, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.I_wb_stb = 1'b0;
      drive(1, 0, 30'h0, 3'b001, {64'h0, 32'h55AA55AA});
      @(negedge clk);
      check("s6_post_ack", 32'(bus.O_wb_ack), 0);
      check("s6_post_err", 32'(bus.O_wb_err), 0);
      drive(0, 0, 30'h0, 3'b000, '0);
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
